// File: rtl/shift_add_multiplier_if.sv
// Start/busy/done handshake and operand/result bus for the shift-and-add multiplier.
interface shift_add_multiplier_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic               start;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] Product;

    modport master (
        output start, A, B,
        input  busy, done, Product
    );

    modport slave (
        input  start, A, B,
        output busy, done, Product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one ripple-carry partial-product add per clock.
module shift_add_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    shift_add_multiplier_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     hi, lo, addend, sum;
    logic [WIDTH:0]       carry;
    logic                 cout;

    assign hi       = acc_q[2*WIDTH-1:WIDTH];
    assign lo       = acc_q[WIDTH-1:0];
    assign addend   = lo[0] ? mcand_q : '0;
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]     = hi[i] ^ addend[i] ^ carry[i];
        assign carry[i+1] = (hi[i] & addend[i]) | (carry[i] & (hi[i] ^ addend[i]));
    end

    // The stored guard bit is always clear after a shift; folding it in keeps it observed.
    assign cout = carry[WIDTH] | acc_q[2*WIDTH];

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    mcand_d = bus.A;
                    acc_d   = {1'b0, {WIDTH{1'b0}}, bus.B};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = {1'b0, cout, sum, lo[WIDTH-1:1]};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    product_d = acc_d[2*WIDTH-1:0];
                    done_d    = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.Product = product_q;
endmodule
